// File: rtl/i2c_txn_arbiter.sv
// Two-requester arbiter that sequences transactions on a shared bit-slot I2C master.
// Define I2C_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module i2c_txn_arbiter #(
  parameter int MAX_LEN = 4,
  parameter int RST_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_mode,
  input  logic [5:0]  req_len,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  wr_next,
  output logic [1:0]  rd_valid,
  output logic [7:0]  rd_data,
  output logic [1:0]  done,
  output logic        err,
  output logic        busy,
  output logic        m_rst_n,
  output logic        m_en,
  output logic        m_start,
  output logic        m_stop,
  output logic        m_mode,
  output logic [6:0]  m_address,
  output logic [7:0]  m_registor,
  input  logic [7:0]  m_data_out,
  input  logic        m_sda
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MRST = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_STP  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic [2:0] state;
  logic [7:0] cnt;
  logic [2:0] byte_idx;
  logic [2:0] len_q;
  logic       win;
  logic [6:0] addr_q;
  logic       mode_q;
  logic       err_q;
  logic       m_rst_q;
  logic [7:0] registor_q;
  logic [7:0] rd_data_q;
  logic [1:0] rd_valid_q;
`ifdef I2C_ARB_RR_EN
  logic       last_win;
`endif

  logic       pick;
  logic [1:0] win_oh;
  logic [7:0] wdata_win;
  logic       last_byte;
  logic       ack_slot;

  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    if (l == 3'd0)
      return 3'd1;
    else if (int'(l) > MAX_LEN)
      return 3'(MAX_LEN);
    else
      return l;
  endfunction

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick = 1'b0;
`ifdef I2C_ARB_RR_EN
    if (req == 2'b11)
      pick = ~last_win;
    else
      pick = ~req[0];
`else
    pick = ~req[0];
`endif
  end

  assign win_oh    = win ? 2'b10 : 2'b01;
  assign wdata_win = win ? req_wdata[15:8] : req_wdata[7:0];
  assign last_byte = (byte_idx == len_q - 3'd1);
  assign ack_slot  = (state == S_DATA) && (cnt == 8'd8);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      byte_idx   <= 3'd0;
      len_q      <= 3'd1;
      win        <= 1'b0;
      addr_q     <= 7'd0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      m_rst_q    <= 1'b0;
      registor_q <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 2'b00;
`ifdef I2C_ARB_RR_EN
      last_win   <= 1'b1;
`endif
    end else begin
      m_rst_q    <= 1'b1;
      rd_valid_q <= 2'b00;
      case (state)
        S_IDLE: begin
          // Grant only once the master has come out of reset, so m_rst_n rises first.
          if ((|req) && m_rst_q) begin
            state   <= S_MRST;
            cnt     <= 8'd0;
            win     <= pick;
            addr_q  <= pick ? req_addr[13:7] : req_addr[6:0];
            mode_q  <= pick ? req_mode[1] : req_mode[0];
            len_q   <= clamp_len(pick ? req_len[5:3] : req_len[2:0]);
            err_q   <= 1'b0;
            m_rst_q <= 1'b0;
`ifdef I2C_ARB_RR_EN
            last_win <= pick;
`endif
          end
        end
        S_MRST: begin
          if (cnt == 8'(RST_CYC - 1)) begin
            state <= S_ARM;
            cnt   <= 8'd0;
          end else begin
            cnt     <= cnt + 8'd1;
            m_rst_q <= 1'b0;
          end
        end
        S_ARM: begin
          state <= S_HDR;
          cnt   <= 8'd0;
        end
        S_HDR: begin
          if (cnt == 8'd9) begin
            cnt <= 8'd0;
            if (m_sda) begin
              err_q <= 1'b1;
              state <= S_STP;
            end else begin
              state    <= S_DATA;
              byte_idx <= 3'd0;
              if (!mode_q) registor_q <= wdata_win;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (ack_slot) begin
            cnt <= 8'd0;
            if (mode_q) begin
              rd_data_q  <= m_data_out;
              rd_valid_q <= win_oh;
            end
            if (last_byte) begin
              state <= S_STP;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              // The requester presents its next byte during the ack slot that pulsed wr_next.
              if (!mode_q) registor_q <= wdata_win;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_STP: begin
          if (cnt == 8'd1) begin
            state <= S_FIN;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign gnt        = busy ? win_oh : 2'b00;
  assign done       = (state == S_FIN) ? win_oh : 2'b00;
  assign err        = (state == S_FIN) && err_q;
  assign wr_next    = (ack_slot && !mode_q && !last_byte) ? win_oh : 2'b00;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign m_rst_n    = m_rst_q;
  assign m_en       = (state == S_ARM);
  assign m_start    = (state == S_ARM);
  // After a NACK the master stops on its own, so m_stop is only driven on the data path.
  assign m_stop     = ((state == S_DATA) && last_byte) || ((state == S_STP) && !err_q);
  assign m_mode     = mode_q;
  assign m_address  = addr_q;
  assign m_registor = registor_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: write, read, NACK, length clamping, arbitration, reset abort.
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [13:0] req_addr = 14'd0;
  logic [1:0]  req_mode = 2'b00;
  logic [5:0]  req_len = 6'd0;
  logic [15:0] req_wdata = 16'd0;
  logic [1:0]  gnt, wr_next, rd_valid, done;
  logic [7:0]  rd_data;
  logic        err, busy;
  logic        m_rst_n, m_en, m_start, m_stop, m_mode;
  logic [6:0]  m_address;
  logic [7:0]  m_registor;
  logic [7:0]  m_data_out = 8'd0;
  logic        m_sda = 1'b0;

  int checks = 0;
  int errors = 0;

  i2c_txn_arbiter #(.MAX_LEN(4), .RST_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_mode(req_mode),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .wr_next(wr_next),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err), .busy(busy),
    .m_rst_n(m_rst_n), .m_en(m_en), .m_start(m_start), .m_stop(m_stop), .m_mode(m_mode),
    .m_address(m_address), .m_registor(m_registor), .m_data_out(m_data_out), .m_sda(m_sda)
  );

  always #5 clk = ~clk;

  // Observations gathered per transaction, relative to the m_start cycle.
  int k, s_cyc, done_cyc, stop_first, stop_cnt, rstlow_cnt, start_cnt, wr_cnt, rdv_cnt, done_cnt;
  logic       err_at_done, mode_at_start, timed_out;
  logic [1:0] done_val, gnt_at_start, rdv_who;
  logic [7:0] reg_b0, reg_b1, rd_seen;
  logic [6:0] addr_at_start;
  logic [7:0] wq [2][4];
  int         wq_idx [2];

  task automatic observe(input int budget);
    k = 0; s_cyc = -1; done_cyc = -1; stop_first = -1; stop_cnt = 0; rstlow_cnt = 0;
    start_cnt = 0; wr_cnt = 0; rdv_cnt = 0; done_cnt = 0; err_at_done = 1'bx;
    done_val = 2'b00; gnt_at_start = 2'b00; rdv_who = 2'b00; reg_b0 = 8'hxx; reg_b1 = 8'hxx;
    rd_seen = 8'hxx; addr_at_start = 7'hxx; mode_at_start = 1'bx;
    wq_idx[0] = 0; wq_idx[1] = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (!m_rst_n) rstlow_cnt++;
      if (m_start) begin
        start_cnt++; s_cyc = k; gnt_at_start = gnt; addr_at_start = m_address; mode_at_start = m_mode;
      end
      if (s_cyc >= 0 && k == s_cyc + 11) reg_b0 = m_registor;
      if (s_cyc >= 0 && k == s_cyc + 20) reg_b1 = m_registor;
      if (m_stop) begin
        if (stop_first < 0) stop_first = k - s_cyc;
        stop_cnt++;
      end
      if (rd_valid != 2'b00) begin rdv_cnt++; rd_seen = rd_data; rdv_who = rd_valid; end
      for (int i = 0; i < 2; i++) begin
        if (wr_next[i]) begin
          wr_cnt++;
          if (wq_idx[i] < 3) wq_idx[i]++;
          req_wdata[8*i +: 8] = wq[i][wq_idx[i]];
        end
      end
      if (done != 2'b00) begin
        done_cnt++; done_val = done; err_at_done = err; done_cyc = k - s_cyc;
      end
    end
    timed_out = (done_cnt == 0);
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({gnt, wr_next, rd_valid, done, err, busy, m_en, m_start, m_stop} !== 13'd0) begin errors++; $display("FAIL reset_ctrl: got %b required 0", {gnt, wr_next, rd_valid, done, err, busy, m_en, m_start, m_stop}); end
    checks++; if (m_rst_n !== 1'b0) begin errors++; $display("FAIL reset_mrst: got %b required 0", m_rst_n); end
    checks++; if ({rd_data, m_address, m_registor} !== 23'd0) begin errors++; $display("FAIL reset_data: got %h required 0", {rd_data, m_address, m_registor}); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (m_rst_n !== 1'b1) begin errors++; $display("FAIL reset_release_mrst: got %b required 1", m_rst_n); end
    @(negedge clk);
  endtask

  task automatic test_write;
    wq[0][0] = 8'hA5; wq[0][1] = 8'h3C; wq[0][2] = 8'h00; wq[0][3] = 8'h00;
    req_wdata = 16'h00A5; req_addr = 14'h0050; req_mode = 2'b00; req_len = 6'o02; m_sda = 1'b0;
    req = 2'b01;
    observe(100);
    req = 2'b00;
    checks++; if (timed_out) begin errors++; $display("FAIL wr_timeout: got no done required done"); end
    checks++; if (gnt_at_start !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b required 01", gnt_at_start); end
    checks++; if ({addr_at_start, mode_at_start} !== {7'h50, 1'b0}) begin errors++; $display("FAIL wr_hdr: got %h/%b required 50/0", addr_at_start, mode_at_start); end
    checks++; if (rstlow_cnt !== 2) begin errors++; $display("FAIL wr_mrst_len: got %0d required 2", rstlow_cnt); end
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL wr_start_cnt: got %0d required 1", start_cnt); end
    checks++; if (reg_b0 !== 8'hA5) begin errors++; $display("FAIL wr_byte0: got %h required a5", reg_b0); end
    checks++; if (reg_b1 !== 8'h3C) begin errors++; $display("FAIL wr_byte1: got %h required 3c", reg_b1); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL wr_next_cnt: got %0d required 1", wr_cnt); end
    checks++; if ({stop_first, stop_cnt} !== {32'd20, 32'd11}) begin errors++; $display("FAIL wr_stop: got %0d/%0d required 20/11", stop_first, stop_cnt); end
    checks++; if ({done_val, err_at_done} !== 3'b010) begin errors++; $display("FAIL wr_done: got %b/%b required 01/0", done_val, err_at_done); end
    checks++; if (done_cyc !== 31) begin errors++; $display("FAIL wr_latency: got %0d required 31", done_cyc); end
    checks++; if (rdv_cnt !== 0) begin errors++; $display("FAIL wr_rdv: got %0d required 0", rdv_cnt); end
    @(negedge clk);
    checks++; if ({busy, gnt} !== 3'b000) begin errors++; $display("FAIL wr_idle: got %b required 000", {busy, gnt}); end
  endtask

  task automatic test_read;
    req_addr = {7'h2A, 7'h00}; req_mode = 2'b10; req_len = 6'o10; m_data_out = 8'h96; m_sda = 1'b0;
    req = 2'b10;
    observe(100);
    req = 2'b00;
    checks++; if (timed_out) begin errors++; $display("FAIL rd_timeout: got no done required done"); end
    checks++; if ({gnt_at_start, addr_at_start, mode_at_start} !== {2'b10, 7'h2A, 1'b1}) begin errors++; $display("FAIL rd_hdr: got %b/%h/%b required 10/2a/1", gnt_at_start, addr_at_start, mode_at_start); end
    checks++; if ({rdv_cnt, rdv_who, rd_seen} !== {32'd1, 2'b10, 8'h96}) begin errors++; $display("FAIL rd_data: got %0d/%b/%h required 1/10/96", rdv_cnt, rdv_who, rd_seen); end
    checks++; if ({stop_first, stop_cnt} !== {32'd11, 32'd11}) begin errors++; $display("FAIL rd_stop: got %0d/%0d required 11/11", stop_first, stop_cnt); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rd_wr_next: got %0d required 0", wr_cnt); end
    checks++; if ({done_val, err_at_done} !== 3'b100) begin errors++; $display("FAIL rd_done: got %b/%b required 10/0", done_val, err_at_done); end
    checks++; if (done_cyc !== 22) begin errors++; $display("FAIL rd_latency: got %0d required 22", done_cyc); end
    @(negedge clk);
  endtask

  task automatic test_nack;
    req_addr = 14'h0011; req_mode = 2'b00; req_len = 6'o02; m_sda = 1'b1;
    req = 2'b01;
    observe(100);
    req = 2'b00; m_sda = 1'b0;
    checks++; if (timed_out) begin errors++; $display("FAIL nack_timeout: got no done required done"); end
    checks++; if ({done_val, err_at_done} !== 3'b011) begin errors++; $display("FAIL nack_err: got %b/%b required 01/1", done_val, err_at_done); end
    checks++; if (done_cyc !== 13) begin errors++; $display("FAIL nack_latency: got %0d required 13", done_cyc); end
    checks++; if ({wr_cnt, rdv_cnt, stop_cnt} !== {32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL nack_no_data: got %0d/%0d/%0d required 0/0/0", wr_cnt, rdv_cnt, stop_cnt); end
    @(negedge clk);
  endtask

  task automatic test_len_clamp;
    wq[0][0] = 8'h11; wq[0][1] = 8'h22; wq[0][2] = 8'h33; wq[0][3] = 8'h44;
    req_wdata = 16'h0011; req_addr = 14'h0021; req_mode = 2'b00; req_len = 6'o00;
    req = 2'b01;
    observe(100);
    req = 2'b00;
    checks++; if ({done_cyc, wr_cnt} !== {32'd22, 32'd0}) begin errors++; $display("FAIL len0: got %0d/%0d required 22/0", done_cyc, wr_cnt); end
    @(negedge clk);
    req_wdata = 16'h0011; req_len = 6'o07;
    req = 2'b01;
    observe(150);
    req = 2'b00;
    checks++; if ({done_cyc, wr_cnt, stop_first} !== {32'd49, 32'd3, 32'd38}) begin errors++; $display("FAIL len_max: got %0d/%0d/%0d required 49/3/38", done_cyc, wr_cnt, stop_first); end
    checks++; if (reg_b1 !== 8'h22) begin errors++; $display("FAIL len_max_byte1: got %h required 22", reg_b1); end
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    logic [1:0] first_gnt, second_exp;
`ifdef I2C_ARB_RR_EN
    second_exp = 2'b10;
`else
    second_exp = 2'b01;
`endif
    req_addr = {7'h12, 7'h34}; req_mode = 2'b00; req_len = 6'o11; req_wdata = 16'h0000;
    req = 2'b11;
    observe(100);
    first_gnt = gnt_at_start;
    checks++; if (timed_out || first_gnt !== 2'b01) begin errors++; $display("FAIL arb_first: got %b required 01", first_gnt); end
    // Let the second grant land, then drop both requests mid-transaction.
    @(negedge clk); @(negedge clk);
    req = 2'b00;
    observe(100);
    checks++; if (timed_out || gnt_at_start !== second_exp) begin errors++; $display("FAIL arb_second: got %b required %b", gnt_at_start, second_exp); end
    checks++; if (done_val !== second_exp) begin errors++; $display("FAIL arb_drop_req_done: got %b required %b", done_val, second_exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    int done_seen;
    req_addr = 14'h0050; req_mode = 2'b00; req_len = 6'o04; req_wdata = 16'h00C3;
    req = 2'b01;
    n = 0;
    while (!m_start && n < 50) begin @(negedge clk); n++; end
    checks++; if (!m_start) begin errors++; $display("FAIL rst_mid_start: got no m_start required m_start"); end
    repeat (15) @(negedge clk);
    req = 2'b00;
    reset_n = 1'b0;
    #1;
    checks++; if ({gnt, wr_next, rd_valid, done, err, busy, m_en, m_start, m_stop, m_rst_n} !== 14'd0) begin errors++; $display("FAIL rst_mid_ctrl: got %b required 0", {gnt, wr_next, rd_valid, done, err, busy, m_en, m_start, m_stop, m_rst_n}); end
    checks++; if ({rd_data, m_address, m_registor} !== 23'd0) begin errors++; $display("FAIL rst_mid_data: got %h required 0", {rd_data, m_address, m_registor}); end
    done_seen = 0;
    repeat (3) begin @(negedge clk); if (done != 2'b00) done_seen++; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done != 2'b00) done_seen++; end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d required 0", done_seen); end
    checks++; if ({m_rst_n, busy} !== 2'b10) begin errors++; $display("FAIL rst_mid_after: got %b required 10", {m_rst_n, busy}); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_nack;
    test_len_clamp;
    test_arbitration;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4: maximum bytes per transaction (1..7).
REQ-002 SHALL have parameter RST_CYC, default 2: length of the master-reset pulse, in clk cycles.
REQ-003 SHALL have port clk, input, 1: system clock; also the SCL source for the shared I2C master.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 2: per-requester transaction request, level, held until done.
REQ-006 SHALL have port req_addr, input, 14: 7-bit slave address per requester; requester i uses bits [7i+6:7i].
REQ-007 SHALL have port req_mode, input, 2: per-requester mode, 1=read, 0=write.
REQ-008 SHALL have port req_len, input, 6: 3-bit byte count per requester, 1..MAX_LEN.
REQ-009 SHALL have port req_wdata, input, 16: current write byte per requester.
REQ-010 SHALL have ports gnt output 2 (one-hot grant, held for the whole transaction); wr_next output 2 (1-cycle pulse, next write byte wanted); rd_valid output 2 (1-cycle pulse); rd_data output 8; done output 2 (1-cycle pulse); err output 1 (valid with done, 1 = address NACK); busy output 1.
REQ-011 SHALL have master-side ports m_rst_n, m_en, m_start, m_stop, m_mode (outputs, 1 each); m_address output 7; m_registor output 8; m_data_out input 8; m_sda input 1 (observed SDA).

Function
REQ-012 SHALL update all state on posedge clk; the master advances on negedge, so each master bit slot equals one clk cycle.
REQ-013 SHALL implement states IDLE, MRST, ARM, HDR, DATA, STP, FIN.
REQ-014 IDLE: with any req high, SHALL choose a winner, latch its addr/mode/len, assert its gnt and go to MRST.
REQ-015 MRST: SHALL drive m_rst_n=0 for RST_CYC cycles, then go to ARM; this clears the master out of its terminal DONE state.
REQ-016 ARM: SHALL drive m_en=1 and m_start=1 for exactly 1 cycle, then go to HDR; m_address and m_mode SHALL stay stable from ARM until FIN.
REQ-017 HDR: SHALL last 10 cycles (START, 7 address bits, mode, ack), then sample m_sda in the ack slot.
REQ-018 If the sampled m_sda is 1 (NACK), SHALL go to STP with err=1; the master self-stops.
REQ-019 DATA: SHALL use 9-cycle byte slots (8 bits plus ack) with a byte counter from 0 to len-1.
REQ-020 Write: m_registor SHALL be loaded from the winner's req_wdata before bit 0 of each byte; wr_next SHALL pulse in each ack slot except the last byte's.
REQ-021 Read: at each byte's ack slot, SHALL set rd_data=m_data_out and pulse rd_valid for the winner.
REQ-022 SHALL assert m_stop from the start of the last byte slot until FIN.
REQ-023 STP: SHALL last 2 cycles (STOP, DONE), then go to FIN.
REQ-024 FIN: SHALL pulse done for the winner, drop gnt and busy, and return to IDLE.
REQ-025 SHALL hold busy=1 in every state except IDLE.
REQ-026 SHALL treat req_len=0 as 1 and req_len>MAX_LEN as MAX_LEN.
REQ-027 Requests arriving during a transaction SHALL wait; the winner dropping req mid-transaction SHALL be ignored until FIN.
REQ-028 Simultaneous req=2'b11 in IDLE SHALL be resolved per REQ-031.

Reset
REQ-029 While reset_n=0, SHALL be in IDLE with gnt, wr_next, rd_valid, done, err, busy, m_en, m_start and m_stop all 0, m_rst_n=0, and rd_data, m_address and m_registor all 0.
REQ-030 After reset release, m_rst_n SHALL go to 1 on the first clk; reset_n low mid-transaction SHALL abort with no done pulse.

Configuration
REQ-031 Macro I2C_ARB_RR_EN: when defined, SHALL use round-robin arbitration; the last winner has lowest priority and the last-winner register resets to requester 1, so requester 0 wins first. When undefined, requester 0 SHALL always have fixed priority.

Verification
REQ-032 Write test: req[0] with addr 0x50, mode 0, len 2, wdata 0xA5 then 0x3C -> the master shifts 1010000,0,A5,3C; wr_next[0] pulses once; done[0] with err=0.
REQ-033 Read test: req[1] with mode 1, len 1, slave returns 0x96 -> rd_valid[1] with rd_data=0x96, m_stop high in the byte slot, done[1].
REQ-034 NACK test: m_sda=1 in the ack slot -> err=1 with done, and no DATA cycles.
REQ-035 Arbitration test: req=11 held over two transactions -> grants 0 then 1 with I2C_ARB_RR_EN, and 0 then 0 without it.
REQ-036 Reset test: reset_n low mid-DATA -> all outputs reach their reset values, with no done pulse.
